// File: rtl/sctag_cpx_req_ctl.sv
`default_nettype none
// ============================================================================
// sctag_cpx_req_ctl : scache-side CPX req/atom/grant transmitter with an
// outbound FIFO and per-core credits. Optional: CPX_REQ_BYPASS_EN. Rev 1.0
// ============================================================================
module sctag_cpx_req_ctl #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 2
) (
  input  logic         rclk,
  input  logic         arst_l,
  input  logic         oq_enq_vld,
  input  logic [2:0]   oq_enq_cpu_id,
  input  logic         oq_enq_atom,
  input  logic [144:0] oq_enq_data,
  output logic         oq_full,
  output logic         oq_ovf_err,
  output logic [7:0]   scache_cpx_req_cq,
  output logic         scache_cpx_atom_cq,
  output logic [144:0] scache_cpx_data_ca,
  input  logic [7:0]   cpx_scache_grant_cx
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = $clog2(CREDITS + 1);
  localparam logic [AW:0]   C_DEPTH   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] C_CREDITS = CW'(CREDITS);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ATOM2 = 1'b1} state_t;
  state_t state_q, state_d;

  logic [2:0]    fifo_cpu_q  [DEPTH];
  logic          fifo_atom_q [DEPTH];
  logic [144:0]  fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] credit_q [8];
  logic [CW-1:0] credit_d [8];
  logic [2:0]    atom_cpu_q;
  logic          ovf_q;
  logic [7:0]    req_q;
  logic          atom_q;
  logic [144:0]  stage_q, data_q;

  logic          head_vld, head_atom;
  logic [2:0]    head_cpu;
  logic [144:0]  head_data;
  logic          pop, byp, issue, push, full;
  logic [2:0]    iss_cpu;
  logic          iss_atom;
  logic [144:0]  iss_data;

  assign head_vld  = (cnt_q != '0);
  assign head_cpu  = fifo_cpu_q[rd_ptr_q];
  assign head_atom = fifo_atom_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign full      = (cnt_q == C_DEPTH);

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    byp      = 1'b0;
    iss_cpu  = head_cpu;
    iss_atom = head_atom;
    iss_data = head_data;
    case (state_q)
      S_IDLE: begin
        if (head_vld) begin
          if (!head_atom && credit_q[head_cpu] != '0) begin
            pop = 1'b1;
          end else if (head_atom && credit_q[head_cpu] == C_CREDITS) begin
            pop     = 1'b1;
            state_d = S_ATOM2;
          end
        end
`ifdef CPX_REQ_BYPASS_EN
        else if (oq_enq_vld && !oq_enq_atom && credit_q[oq_enq_cpu_id] != '0) begin
          byp      = 1'b1;
          iss_cpu  = oq_enq_cpu_id;
          iss_atom = 1'b0;
          iss_data = oq_enq_data;
        end
`endif
      end
      S_ATOM2: begin
        // Second half of the pair: both credits were reserved by the first.
        if (head_vld) begin
          pop      = 1'b1;
          iss_atom = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign issue = pop | byp;
  assign push  = oq_enq_vld && !byp && (!full || pop);
  assign cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      credit_d[i] = credit_q[i];
      if (issue && iss_cpu == 3'(i)) begin
        if (!cpx_scache_grant_cx[i] && credit_q[i] != '0)
          credit_d[i] = credit_q[i] - CW'(1);
      end else if (cpx_scache_grant_cx[i] && credit_q[i] != C_CREDITS) begin
        credit_d[i] = credit_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (push) begin
      fifo_cpu_q[wr_ptr_q]  <= oq_enq_cpu_id;
      fifo_atom_q[wr_ptr_q] <= oq_enq_atom;
      fifo_data_q[wr_ptr_q] <= oq_enq_data;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      atom_cpu_q <= '0;
      ovf_q      <= 1'b0;
      req_q      <= '0;
      atom_q     <= 1'b0;
      stage_q    <= '0;
      data_q     <= '0;
      for (int i = 0; i < 8; i++) credit_q[i] <= C_CREDITS;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (oq_enq_vld && full && !pop) ovf_q <= 1'b1;
      if (issue && iss_atom) atom_cpu_q <= iss_cpu;
      req_q  <= issue ? (8'b1 << iss_cpu) : 8'b0;
      atom_q <= issue & iss_atom;
      // Payload trails its req by one cycle through the staging register.
      if (issue) stage_q <= iss_data;
      if (req_q != '0) data_q <= stage_q;
    end
  end

  assign oq_full            = full;
  assign oq_ovf_err         = ovf_q;
  assign scache_cpx_req_cq  = req_q;
  assign scache_cpx_atom_cq = atom_q;
  assign scache_cpx_data_ca = data_q;

`ifndef SYNTHESIS
  for (genvar g = 0; g < 8; g++) begin : g_cred_chk
    a_grant_sat: assert property (@(posedge rclk) disable iff (!arst_l)
      !(cpx_scache_grant_cx[g] && credit_q[g] == C_CREDITS && !(issue && iss_cpu == 3'(g))));
  end
  a_atom_cpu: assert property (@(posedge rclk) disable iff (!arst_l)
    (state_q == S_ATOM2 && head_vld) |-> (head_cpu == atom_cpu_q));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sctag_cpx_req_ctl.sv
`default_nettype none
// tb_sctag_cpx_req_ctl : vector tables per scenario, payload order checked
// through a scoreboard queue.
module tb_sctag_cpx_req_ctl;

  logic         clk = 1'b0;
  logic         arst_l = 1'b0;
  logic         vld = 1'b0;
  logic [2:0]   cpu = '0;
  logic         atm = 1'b0;
  logic [144:0] din = '0;
  logic [7:0]   grant = '0;
  logic         full, ovf, atom_o;
  logic [7:0]   req;
  logic [144:0] dout;

  sctag_cpx_req_ctl #(.DEPTH(4), .CREDITS(2)) dut (
    .rclk               (clk),
    .arst_l             (arst_l),
    .oq_enq_vld         (vld),
    .oq_enq_cpu_id      (cpu),
    .oq_enq_atom        (atm),
    .oq_enq_data        (din),
    .oq_full            (full),
    .oq_ovf_err         (ovf),
    .scache_cpx_req_cq  (req),
    .scache_cpx_atom_cq (atom_o),
    .scache_cpx_data_ca (dout),
    .cpx_scache_grant_cx(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [2:0]   cpu;
    logic         atom;
    logic [144:0] data;
    logic [7:0]   grant;
    logic         drop;
    logic [7:0]   ereq;
    logic         eatom;
    logic         efull;
    logic         eovf;
  } vec_t;

  vec_t         tv[$];
  logic [144:0] sb[$];
  int           n_vec = 0;
  int           n_err = 0;

`ifdef CPX_REQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [144:0] mk(input int id);
    logic [31:0] w;
    w = 32'(id) ^ 32'hA5A5_0000;
    return {id[16:0], w, ~w, w + 32'd7, w ^ 32'h1234_5678};
  endfunction

  task automatic add(input logic v, input logic [2:0] c, input logic a, input logic [144:0] d,
                     input logic [7:0] g, input logic dr, input logic [7:0] er, input logic ea,
                     input logic ef, input logic eo);
    vec_t t;
    t.vld = v; t.cpu = c; t.atom = a; t.data = d; t.grant = g; t.drop = dr;
    t.ereq = er; t.eatom = ea; t.efull = ef; t.eovf = eo;
    tv.push_back(t);
  endtask

  task automatic enq(input logic [2:0] c, input logic a, input logic [144:0] d, input logic [7:0] er,
                     input logic ea);
    add(1'b1, c, a, d, 8'h00, 1'b0, er, ea, 1'b0, 1'b0);
  endtask

  task automatic nop(input logic [7:0] er, input logic ea, input logic ef, input logic eo);
    add(1'b0, 3'd0, 1'b0, '0, 8'h00, 1'b0, er, ea, ef, eo);
  endtask

  task automatic run_seg(input int seg);
    logic [7:0]   prev_req;
    logic [144:0] exp_d;
    prev_req = '0;
    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      n_vec++;
      if (req !== tv[k].ereq || atom_o !== tv[k].eatom || full !== tv[k].efull || ovf !== tv[k].eovf) begin
        n_err++;
        $display("FAIL seg%0d vec%0d outputs: req=%h atom=%b full=%b ovf=%b, expected req=%h atom=%b full=%b ovf=%b",
                 seg, k, req, atom_o, full, ovf, tv[k].ereq, tv[k].eatom, tv[k].efull, tv[k].eovf);
      end
      if (prev_req != '0) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL seg%0d vec%0d data: got %h, scoreboard empty", seg, k, dout);
        end else begin
          exp_d = sb.pop_front();
          if (dout !== exp_d) begin
            n_err++;
            $display("FAIL seg%0d vec%0d data: got %h expected %h", seg, k, dout, exp_d);
          end
        end
      end
      prev_req = tv[k].ereq;
      vld = tv[k].vld; cpu = tv[k].cpu; atm = tv[k].atom; din = tv[k].data; grant = tv[k].grant;
      if (tv[k].vld && !tv[k].drop) sb.push_back(tv[k].data);
    end
    @(negedge clk);
    vld = 1'b0; atm = 1'b0; grant = '0;
    tv.delete();
  endtask

  // Async assert away from any edge; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    arst_l = 1'b0; vld = 1'b0; grant = 8'hFF;
    #1;
    n_vec++;
    if (req !== 8'h00 || atom_o !== 1'b0 || dout !== '0 || full !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset %s: req=%h atom=%b data=%h full=%b ovf=%b, expected all zero",
               tag, req, atom_o, dout, full, ovf);
    end
    repeat (2) @(negedge clk);
    grant = '0;
    arst_l = 1'b1;
    sb.delete();
  endtask

  initial begin
    do_reset("initial");

    // Single issue, then credit[3]=1 shown by one more issue and a stall.
    enq(3, 0, 145'h1_2345, 8'h00, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h08, 0, 0, 0);
    enq(3, 0, mk(11), 8'h00, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h08, 0, 0, 0);
    enq(3, 0, mk(12), 8'h00, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    add(0, 0, 0, '0, 8'h08, 0, 8'h00, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h08, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    run_seg(1);
    do_reset("seg1");

    // Three to cpu5: two back-to-back, third waits for a grant.
    enq(5, 0, mk(21), 8'h00, 0);
    enq(5, 0, mk(22), 8'h00, 0);
    enq(5, 0, mk(23), 8'h20, 0);
    nop(8'h20, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    add(0, 0, 0, '0, 8'h20, 0, 8'h00, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h20, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    run_seg(2);
    do_reset("seg2");

    // Atomic pair held at credit 1, released by a grant, leaves credit 0.
    enq(0, 0, mk(31), 8'h00, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h01, 0, 0, 0);
    enq(0, 1, mk(32), 8'h00, 0);
    enq(0, 0, mk(33), 8'h00, 0);
    nop(8'h00, 0, 0, 0);
    add(0, 0, 0, '0, 8'h01, 0, 8'h00, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h01, 1, 0, 0);
    nop(8'h01, 0, 0, 0);
    enq(0, 0, mk(34), 8'h00, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    add(0, 0, 0, '0, 8'h01, 0, 8'h00, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h01, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    run_seg(3);
    do_reset("seg3");

    // Starve cpu7, fill, overflow, then enqueue+pop while full.
    enq(7, 0, mk(41), 8'h00, 0);
    enq(7, 0, mk(42), 8'h00, 0);
    enq(7, 0, mk(43), 8'h80, 0);
    enq(7, 0, mk(44), 8'h80, 0);
    enq(7, 0, mk(45), 8'h00, 0);
    enq(7, 0, mk(46), 8'h00, 0);
    add(1, 7, 0, mk(47), 8'h00, 1, 8'h00, 0, 1, 0);
    nop(8'h00, 0, 1, 1);
    add(0, 0, 0, '0, 8'h80, 0, 8'h00, 0, 1, 1);
    add(1, 7, 0, mk(48), 8'h00, 0, 8'h00, 0, 1, 1);
    nop(8'h80, 0, 1, 1);
    nop(8'h00, 0, 1, 1);
    run_seg(4);
    do_reset("seg4");

    // Issue and grant to cpu2 in one cycle at credit 1: credit stays 1.
    enq(2, 0, mk(51), 8'h00, 0);
    enq(2, 0, mk(52), 8'h00, 0);
    add(1, 2, 0, mk(53), 8'h04, 0, 8'h04, 0, 0, 0);
    enq(2, 0, mk(54), 8'h04, 0);
    nop(8'h04, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    run_seg(5);
    do_reset("mid-queue");

    // Queue emptied and credits full again; back-to-back to different cores.
    enq(2, 1, mk(61), 8'h00, 0);
    enq(2, 0, mk(62), 8'h00, 0);
    enq(1, 0, mk(63), 8'h04, 1);
    enq(6, 0, mk(64), 8'h04, 0);
    nop(8'h02, 0, 0, 0);
    nop(8'h40, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    run_seg(6);
    do_reset("seg6");

    // Single-entry latency: N+1 with bypass, N+2 without.
    enq(4, 0, mk(71), 8'h00, 0);
    nop(BYP ? 8'h10 : 8'h00, 0, 0, 0);
    nop(BYP ? 8'h00 : 8'h10, 0, 0, 0);
    nop(8'h00, 0, 0, 0);
    run_seg(7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
